// File: rtl/redmule_w_dbuf.sv
// redmule_w_dbuf -- double-buffered weight staging buffer.
//
// Two banks of H rows x D elements. Rows are loaded one at a time into the
// write bank. A bank becomes readable once its last row lands. The read side
// presents one element per row on w_o and walks the element index on each
// shift_i. After reps_i full passes it hands the bank back to the writer.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush of counters/pointers/flags
//   load_valid_i/ready_o   row handshake; load_data_i carries D elements
//   width_i, height_i      valid elements per row / valid rows per bank
//   reps_i                 read passes per bank (0 behaves as 1)
//   shift_i                advance the read element index
//   w_o, w_valid_o         one element per row, valid while read bank full
//   full_o                 per-bank full flags

// Storage for one row position across both banks.
module redmule_w_dbuf_row #(
    parameter int unsigned D    = 18,
    parameter int unsigned BITW = 16,
    parameter int unsigned IW   = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 we_i,
    input  logic [D-1:0][BITW-1:0]     row_i,
    input  logic                       rd_bank_i,
    input  logic [IW-1:0]              rd_idx_i,
    output logic [BITW-1:0]            elem_o
);

    logic [1:0][D-1:0][BITW-1:0] mem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (we_i[b]) mem_q[b] <= row_i;
            end
        end
    end

    assign elem_o = mem_q[rd_bank_i][rd_idx_i];

endmodule

module redmule_w_dbuf #(
    parameter int unsigned DW   = 288,
    parameter int unsigned BITW = 16,
    parameter int unsigned H    = 4,
    localparam int unsigned D   = DW / BITW,
    localparam int unsigned RW  = $clog2(H + 1),
    localparam int unsigned IW  = $clog2(D)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                load_valid_i,
    output logic                load_ready_o,
    input  logic [DW-1:0]       load_data_i,
    input  logic [IW:0]         width_i,
    input  logic [RW-1:0]       height_i,
    input  logic [7:0]          reps_i,
    input  logic                shift_i,
    output logic [H*BITW-1:0]   w_o,
    output logic                w_valid_o,
    output logic [1:0]          full_o
);

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [RW-1:0]     wr_row_q,  wr_row_d;
    logic [IW-1:0]     rd_idx_q,  rd_idx_d;
    logic [7:0]        rd_pass_q, rd_pass_d;
    logic [1:0]        full_q,    full_d;

    logic              accept, shift_ok, row_last, idx_last, pass_last;
    logic [7:0]        reps_eff;
    logic              row_in_range;

    logic [D-1:0][BITW-1:0] wr_row_data;
    logic [H-1:0][BITW-1:0] lane;

    assign load_ready_o = !full_q[wr_bank_q];
    assign w_valid_o    = full_q[rd_bank_q];
    assign full_o       = full_q;

    assign accept    = load_valid_i && load_ready_o;
    assign shift_ok  = shift_i && w_valid_o;
    assign row_last  = (wr_row_q == RW'(H - 1));
    assign idx_last  = (rd_idx_q == IW'(D - 1));
    assign reps_eff  = (reps_i == 8'd0) ? 8'd1 : reps_i;
    assign pass_last = (rd_pass_q == reps_eff - 8'd1);

    // Rows beyond height_i are stored as all-zero so the read side never
    // has to know the configured shape.
    assign row_in_range = (wr_row_q < height_i);

    for (genvar d = 0; d < D; d++) begin : g_pad
        assign wr_row_data[d] = (row_in_range && (width_i > (IW+1)'(d)))
                              ? load_data_i[d*BITW +: BITW] : '0;
    end

    for (genvar h = 0; h < H; h++) begin : g_row
        logic       hit;
        logic [1:0] we;
        // clear_i wins over a load offered in the same cycle.
        assign hit = accept && !clear_i && (wr_row_q == RW'(h));
        assign we  = {hit && wr_bank_q, hit && !wr_bank_q};

        redmule_w_dbuf_row #(
            .D    (D),
            .BITW (BITW),
            .IW   (IW)
        ) i_row (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .we_i      (we),
            .row_i     (wr_row_data),
            .rd_bank_i (rd_bank_q),
            .rd_idx_i  (rd_idx_q),
            .elem_o    (lane[h])
        );
    end

    assign w_o = w_valid_o ? lane : '0;

    // Read and write sides only ever touch different banks in the same
    // cycle (write needs !full, release needs full), so both updates to
    // full_d can be applied independently.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_idx_d  = rd_idx_q;
        rd_pass_d = rd_pass_q;
        full_d    = full_q;
        if (clear_i) begin
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_row_d  = '0;
            rd_idx_d  = '0;
            rd_pass_d = '0;
            full_d    = '0;
        end else begin
            if (shift_ok) begin
                if (idx_last) begin
                    rd_idx_d = '0;
                    if (pass_last) begin
                        rd_pass_d         = '0;
                        rd_bank_d         = !rd_bank_q;
                        full_d[rd_bank_q] = 1'b0;
                    end else begin
                        rd_pass_d = rd_pass_q + 8'd1;
                    end
                end else begin
                    rd_idx_d = rd_idx_q + IW'(1);
                end
            end
            if (accept) begin
                if (row_last) begin
                    wr_row_d          = '0;
                    wr_bank_d         = !wr_bank_q;
                    full_d[wr_bank_q] = 1'b1;
                end else begin
                    wr_row_d = wr_row_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_idx_q  <= '0;
            rd_pass_q <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_idx_q  <= rd_idx_d;
            rd_pass_q <= rd_pass_d;
            full_q    <= full_d;
        end
    end

    // Shape and repeat count must hold steady while any bank is mid-load
    // or being read out.
    logic busy;
    assign busy = (wr_row_q != '0) || w_valid_o;

    a_cfg_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni || clear_i)
        busy |-> ($stable(width_i) && $stable(height_i) && $stable(reps_i))
    );

endmodule

// File: tb/tb_redmule_w_dbuf.sv
module tb_redmule_w_dbuf;

    localparam int DW   = 288;
    localparam int BITW = 16;
    localparam int H    = 4;
    localparam int D    = DW / BITW;
    localparam int RW   = $clog2(H + 1);
    localparam int IW   = $clog2(D);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              load_valid_i = 1'b0;
    logic              load_ready_o;
    logic [DW-1:0]     load_data_i = '0;
    logic [IW:0]       width_i = (IW+1)'(D);
    logic [RW-1:0]     height_i = RW'(H);
    logic [7:0]        reps_i = 8'd1;
    logic              shift_i = 1'b0;
    logic [H*BITW-1:0] w_o;
    logic              w_valid_o;
    logic [1:0]        full_o;

    int n_cmp = 0;
    int n_err = 0;

    redmule_w_dbuf #(.DW(DW), .BITW(BITW), .H(H)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_data_i  (load_data_i),
        .width_i      (width_i),
        .height_i     (height_i),
        .reps_i       (reps_i),
        .shift_i      (shift_i),
        .w_o          (w_o),
        .w_valid_o    (w_valid_o),
        .full_o       (full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Filled banks form a FIFO of at most two; the oldest is the one read.
    logic [15:0] m_cur [H][D];
    logic [15:0] m_q   [2][H][D];
    int m_qn, m_rel, m_wrow, m_idx, m_pass;

    task automatic m_reset();
        m_qn = 0; m_rel = 0; m_wrow = 0; m_idx = 0; m_pass = 0;
    endtask

    task automatic m_step();
        bit rdy, vld, acc, sh;
        int reps;
        rdy  = (m_qn < 2);
        vld  = (m_qn > 0);
        acc  = load_valid_i && rdy;
        sh   = shift_i && vld;
        reps = (reps_i == 8'd0) ? 1 : int'(reps_i);
        if (sh) begin
            if (m_idx == D - 1) begin
                m_idx = 0;
                if (m_pass == reps - 1) begin
                    m_pass = 0;
                    m_q[0] = m_q[1];
                    m_qn--;
                    m_rel++;
                end else m_pass++;
            end else m_idx++;
        end
        if (acc) begin
            for (int d = 0; d < D; d++)
                m_cur[m_wrow][d] = (d < int'(width_i) && m_wrow < int'(height_i))
                                   ? load_data_i[d*16 +: 16] : 16'h0;
            if (m_wrow == H - 1) begin
                m_q[m_qn] = m_cur;
                m_qn++;
                m_wrow = 0;
            end else m_wrow++;
        end
    endtask

    // Inputs change just after posedge, so at negedge they are exactly
    // what the DUT will see on the next edge: compare, then advance model.
    always @(negedge clk_i) begin
        logic [1:0]  ef;
        logic [63:0] ew;
        if (!rst_ni) m_reset();
        ef = 2'b00;
        for (int k = 0; k < m_qn; k++) ef[(m_rel + k) % 2] = 1'b1;
        ew = '0;
        for (int h = 0; h < H; h++)
            if (m_qn > 0) ew[h*16 +: 16] = m_q[0][h][m_idx];
        chk("cyc_ready", 64'(load_ready_o), 64'(m_qn < 2));
        chk("cyc_valid", 64'(w_valid_o), 64'(m_qn > 0));
        chk("cyc_full",  64'(full_o), 64'(ef));
        chk("cyc_w",     64'(w_o), ew);
        if (rst_ni) begin
            if (clear_i) m_reset();
            else m_step();
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] mk(input int f, input int r);
        logic [DW-1:0] v;
        v = '0;
        for (int d = 0; d < D; d++) v[d*16 +: 16] = {4'(f), 4'(r), 8'(d)};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_rows(input int f, input int r0, input int n);
        for (int i = 0; i < n; i++) begin
            load_valid_i = 1'b1;
            load_data_i  = mk(f, r0 + i);
            tick();
        end
        load_valid_i = 1'b0;
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) begin
            shift_i = 1'b1;
            tick();
        end
        shift_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
    endtask

    initial begin
        // reset values
        repeat (3) tick();
        chk("rst_ready", 64'(load_ready_o), 64'd1);
        chk("rst_valid", 64'(w_valid_o), 64'd0);
        chk("rst_full",  64'(full_o), 64'd0);
        chk("rst_w",     64'(w_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // fill bank 0
        load_rows(0, 0, 4);
        chk("fill_full",  64'(full_o), 64'h1);
        chk("fill_valid", 64'(w_valid_o), 64'd1);
        chk("fill_ready", 64'(load_ready_o), 64'd1);
        chk("fill_w",     64'(w_o), 64'h0300_0200_0100_0000);

        // fill bank 1, then backpressure and release of bank 0
        load_rows(1, 0, 4);
        chk("bp_full",  64'(full_o), 64'h3);
        chk("bp_ready", 64'(load_ready_o), 64'd0);
        load_rows(9, 0, 2);  // refused: nothing is free
        chk("bp_hold",  64'(full_o), 64'h3);
        shifts(17);
        chk("bp_w17",   64'(w_o), 64'h0311_0211_0111_0011);
        shifts(1);
        chk("bp_full2", 64'(full_o), 64'h2);
        chk("bp_ready2",64'(load_ready_o), 64'd1);
        chk("bp_rdb1",  64'(w_o), 64'h1300_1200_1100_1000);

        // last row of bank 1 lands on the same edge bank 0 is released
        do_clear();
        load_rows(2, 0, 4);
        load_rows(3, 0, 3);
        shifts(17);
        load_valid_i = 1'b1;
        load_data_i  = mk(3, 3);
        shift_i      = 1'b1;
        tick();
        load_valid_i = 1'b0;
        shift_i      = 1'b0;
        chk("cc_full",  64'(full_o), 64'h2);
        chk("cc_valid", 64'(w_valid_o), 64'd1);
        chk("cc_ready", 64'(load_ready_o), 64'd1);
        chk("cc_w",     64'(w_o), 64'h3300_3200_3100_3000);

        // repeats
        do_clear();
        reps_i = 8'd3;
        tick();
        load_rows(4, 0, 4);
        shifts(18);
        chk("rep_w18",   64'(w_o), 64'h4300_4200_4100_4000);
        shifts(35);
        chk("rep_full53",64'(full_o), 64'h1);
        shifts(1);
        chk("rep_full54",64'(full_o), 64'h0);
        chk("rep_valid", 64'(w_valid_o), 64'd0);
        chk("rep_w0",    64'(w_o), 64'd0);

        // padding, with reps 0 behaving as a single pass
        do_clear();
        width_i  = (IW+1)'(5);
        height_i = RW'(3);
        reps_i   = 8'd0;
        tick();
        load_rows(5, 0, 4);
        chk("pad_w0",  64'(w_o), 64'h0000_5200_5100_5000);
        shifts(4);
        chk("pad_w4",  64'(w_o), 64'h0000_5204_5104_5004);
        shifts(1);
        chk("pad_w5v", 64'(w_valid_o), 64'd1);
        chk("pad_w5",  64'(w_o), 64'd0);
        shifts(13);
        chk("pad_rel", 64'(full_o), 64'h0);

        // flush mid-load and mid-read, clear beats load and shift
        width_i  = (IW+1)'(D);
        height_i = RW'(H);
        reps_i   = 8'd1;
        tick();
        load_rows(6, 0, 4);
        load_rows(7, 0, 2);
        shifts(3);
        clear_i      = 1'b1;
        load_valid_i = 1'b1;
        load_data_i  = mk(7, 2);
        shift_i      = 1'b1;
        tick();
        clear_i      = 1'b0;
        load_valid_i = 1'b0;
        shift_i      = 1'b0;
        chk("clr_full",  64'(full_o), 64'h0);
        chk("clr_ready", 64'(load_ready_o), 64'd1);
        chk("clr_valid", 64'(w_valid_o), 64'd0);
        chk("clr_w",     64'(w_o), 64'd0);
        tick();

        // asynchronous reset mid-load and mid-read
        load_rows(8, 0, 4);
        load_rows(9, 0, 2);
        shifts(3);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_full",  64'(full_o), 64'h0);
        chk("arst_ready", 64'(load_ready_o), 64'd1);
        chk("arst_w",     64'(w_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("arst_after", 64'(full_o), 64'h0);
        load_rows(10, 0, 4);
        chk("arst_refill",64'(w_o), 64'hA300_A200_A100_A000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
